// File: rtl/nasti_stream_arbiter.sv
// -----------------------------------------------------------------------------
// nasti_stream_arbiter
//
// Merges up to four input stream lanes onto one output stream. Arbitration is
// round-robin between packets: a lane that wins keeps the output until its
// t_last beat has been accepted, so beats of different packets never
// interleave. The output beat is held in a single register stage that can be
// reloaded in the same cycle it drains, giving one beat per cycle with m_ready
// held high, including across packet boundaries and lane switches.
//
// Ports:
//   clk      - clock, all logic on the rising edge
//   rstn     - asynchronous active-low reset
//   s_valid  - per-lane t_valid            [N_PORT]
//   s_data   - per-lane t_data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_strb   - per-lane t_strb             [N_PORT*DATA_WIDTH/8]
//   s_keep   - per-lane t_keep             [N_PORT*DATA_WIDTH/8]
//   s_last   - per-lane t_last             [N_PORT]
//   s_id     - per-lane t_id               [N_PORT*ID_WIDTH]
//   s_dest   - per-lane t_dest             [N_PORT*DEST_WIDTH]
//   s_user   - per-lane t_user             [N_PORT*USER_WIDTH]
//   s_ready  - per-lane t_ready            [N_PORT]
//   m_valid  - output t_valid
//   m_data, m_strb, m_keep, m_last, m_id, m_dest, m_user - output beat fields
//   m_lane   - source lane of the beat currently on the output
//   m_ready  - output t_ready
// -----------------------------------------------------------------------------
module nasti_stream_arbiter #(
    parameter int N_PORT     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [N_PORT-1:0]                s_valid,
    input  logic [N_PORT*DATA_WIDTH-1:0]     s_data,
    input  logic [N_PORT*DATA_WIDTH/8-1:0]   s_strb,
    input  logic [N_PORT*DATA_WIDTH/8-1:0]   s_keep,
    input  logic [N_PORT-1:0]                s_last,
    input  logic [N_PORT*ID_WIDTH-1:0]       s_id,
    input  logic [N_PORT*DEST_WIDTH-1:0]     s_dest,
    input  logic [N_PORT*USER_WIDTH-1:0]     s_user,
    output logic [N_PORT-1:0]                s_ready,
    output logic                             m_valid,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [DATA_WIDTH/8-1:0]          m_strb,
    output logic [DATA_WIDTH/8-1:0]          m_keep,
    output logic                             m_last,
    output logic [ID_WIDTH-1:0]              m_id,
    output logic [DEST_WIDTH-1:0]            m_dest,
    output logic [USER_WIDTH-1:0]            m_user,
    output logic [1:0]                       m_lane,
    input  logic                             m_ready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [1:0] lock_q, lock_d;
    logic [1:0] rr_q, rr_d;

    logic       load;
    logic       sel_found;
    logic [1:0] sel_lane;
    logic       accept;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [STRB_WIDTH-1:0] sel_strb;
    logic [STRB_WIDTH-1:0] sel_keep;
    logic                  sel_last;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [DEST_WIDTH-1:0] sel_dest;
    logic [USER_WIDTH-1:0] sel_user;

    // The output register can take a new beat when it is empty or is being
    // drained by the consumer in this very cycle.
    assign load = !m_valid || m_ready;

    // Lane selection. While locked the lock lane is the only candidate, valid
    // or not, so a stalled packet keeps the output reserved. While idle the
    // lanes are scanned starting just after the previous winner; the first
    // valid one found wins.
    always_comb begin
        sel_found = 1'b0;
        sel_lane  = '0;
        if (state_q == LOCKED) begin
            sel_found = 1'b1;
            sel_lane  = lock_q;
        end else begin
            for (int k = 1; k <= N_PORT; k++) begin
                for (int i = 0; i < N_PORT; i++) begin
                    if (!sel_found && s_valid[i] &&
                        (i == ((int'(rr_q) + k) % N_PORT))) begin
                        sel_found = 1'b1;
                        sel_lane  = 2'(i);
                    end
                end
            end
        end
    end

    // Only the selected lane ever sees ready, and only when the output
    // register can take its beat. Ready is forced low while in reset.
    always_comb begin
        s_ready = '0;
        for (int i = 0; i < N_PORT; i++) begin
            if (sel_found && (sel_lane == 2'(i))) begin
                s_ready[i] = load && rstn;
            end
        end
    end

    assign accept = |(s_ready & s_valid);

    // Field multiplexer: picks the selected lane's beat out of the packed
    // lane vectors.
    always_comb begin
        sel_data = '0;
        sel_strb = '0;
        sel_keep = '0;
        sel_last = 1'b0;
        sel_id   = '0;
        sel_dest = '0;
        sel_user = '0;
        for (int i = 0; i < N_PORT; i++) begin
            if (sel_lane == 2'(i)) begin
                sel_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb = s_strb[i*STRB_WIDTH +: STRB_WIDTH];
                sel_keep = s_keep[i*STRB_WIDTH +: STRB_WIDTH];
                sel_last = s_last[i];
                sel_id   = s_id[i*ID_WIDTH +: ID_WIDTH];
                sel_dest = s_dest[i*DEST_WIDTH +: DEST_WIDTH];
                sel_user = s_user[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    // Lock FSM next state. A first beat without t_last takes the lock; a
    // single-beat packet only moves the round-robin pointer. Leaving LOCKED
    // leaves the pointer on the lock lane (it was set when the packet
    // started), so the next arbitration begins after it.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        if (accept) begin
            if (state_q == IDLE) begin
                rr_d = sel_lane;
                if (!sel_last) begin
                    state_d = LOCKED;
                    lock_d  = sel_lane;
                end
            end else if (sel_last) begin
                state_d = IDLE;
            end
        end
    end

    // Lock FSM state register. The pointer resets to the top lane so that
    // lane 0 has first priority after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            lock_q  <= '0;
            rr_q    <= 2'(N_PORT - 1);
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rr_q    <= rr_d;
        end
    end

    // Output register. An accepted beat always overwrites it (load guarantees
    // the previous beat is gone or leaving). Without a new beat the register
    // empties when drained and otherwise holds every field stable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_strb  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
            m_id    <= '0;
            m_dest  <= '0;
            m_user  <= '0;
            m_lane  <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= sel_data;
            m_strb  <= sel_strb;
            m_keep  <= sel_keep;
            m_last  <= sel_last;
            m_id    <= sel_id;
            m_dest  <= sel_dest;
            m_user  <= sel_user;
            m_lane  <= sel_lane;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nasti_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nasti_stream_arbiter
//
// Each lane owns a queue of pending beats. Every cycle the stimulus side
// offers lane heads with random valid patterns, predicts from the arbitration
// rules which lane is granted, checks s_ready, and pushes the granted beat
// into a scoreboard. A separate monitor pops the scoreboard whenever an output
// beat is handed over and checks its content, plus stability during stalls.
// -----------------------------------------------------------------------------
module tb_nasti_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [SW-1:0] keep;
        logic          last;
        logic          id;
        logic          dest;
        logic          user;
    } beat_t;

    typedef struct packed {
        logic [1:0] lane;
        beat_t      beat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [N-1:0]      s_valid = '0;
    logic [N*DW-1:0]   s_data = '0;
    logic [N*SW-1:0]   s_strb = '0;
    logic [N*SW-1:0]   s_keep = '0;
    logic [N-1:0]      s_last = '0;
    logic [N-1:0]      s_id = '0;
    logic [N-1:0]      s_dest = '0;
    logic [N-1:0]      s_user = '0;
    logic [N-1:0]      s_ready;
    logic              m_valid;
    logic [DW-1:0]     m_data;
    logic [SW-1:0]     m_strb;
    logic [SW-1:0]     m_keep;
    logic              m_last;
    logic [0:0]        m_id;
    logic [0:0]        m_dest;
    logic [0:0]        m_user;
    logic [1:0]        m_lane;
    logic              m_ready = 1'b0;

    always #5 clk = ~clk;

    nasti_stream_arbiter #(
        .N_PORT(N), .DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_data(s_data), .s_strb(s_strb), .s_keep(s_keep),
        .s_last(s_last), .s_id(s_id), .s_dest(s_dest), .s_user(s_user),
        .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_strb(m_strb), .m_keep(m_keep),
        .m_last(m_last), .m_id(m_id), .m_dest(m_dest), .m_user(m_user),
        .m_lane(m_lane), .m_ready(m_ready)
    );

    beat_t lane_q[N][$];
    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    pv[N];
    int    pready = 100;

    // Reference model state: the lane owning the output (-1 when free), the
    // most recent winner, and whether the output register holds a beat.
    int    owner = -1;
    int    last_winner = N - 1;
    bit    mv = 1'b0;

    bit    stalled = 1'b0;
    exp_t  stall_snap;

    task automatic cmp(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic pushPacket(input int lane, input int len, input logic [DW-1:0] base, input bit fixed);
        for (int k = 0; k < len; k++) begin
            beat_t b;
            b.data = fixed ? base + DW'(k) : {$urandom, $urandom};
            b.strb = SW'($urandom);
            b.keep = SW'($urandom);
            b.last = (k == len - 1);
            b.id   = 1'($urandom);
            b.dest = 1'($urandom);
            b.user = 1'($urandom);
            lane_q[lane].push_back(b);
        end
    endtask

    task automatic setProbs(input int p0, input int p1, input int p2, input int p3, input int pr);
        pv[0] = p0; pv[1] = p1; pv[2] = p2; pv[3] = p3; pready = pr;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic applyStimulus();
        logic [N-1:0] exp_ready;
        bit           load;
        int           win;
        beat_t        b;
        cmp("m_valid", 96'(m_valid), 96'(mv));
        for (int i = 0; i < N; i++) begin
            b = '0;
            if (lane_q[i].size() > 0) b = lane_q[i][0];
            s_valid[i] = (lane_q[i].size() > 0) && ($urandom_range(0, 99) < pv[i]);
            s_data[i*DW +: DW] = b.data;
            s_strb[i*SW +: SW] = b.strb;
            s_keep[i*SW +: SW] = b.keep;
            s_last[i] = b.last;
            s_id[i]   = b.id;
            s_dest[i] = b.dest;
            s_user[i] = b.user;
        end
        m_ready = ($urandom_range(0, 99) < pready);
        #1;
        load = !mv || m_ready;
        win = -1;
        exp_ready = '0;
        if (owner >= 0) begin
            if (load) exp_ready = 4'b0001 << owner;
            if (load && s_valid[owner]) win = owner;
        end else if (load) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last_winner + k) % N;
                if (win < 0 && s_valid[c]) win = c;
            end
            if (win >= 0) exp_ready = 4'b0001 << win;
        end
        cmp("s_ready", 96'(s_ready), 96'(exp_ready));
        if (win >= 0) begin
            b = lane_q[win].pop_front();
            sb.push_back({2'(win), b});
            last_winner = win;
            owner = b.last ? -1 : win;
            mv = 1'b1;
        end else if (m_ready) begin
            mv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; reset spans one full cycle.
    task automatic doReset();
        rstn = 1'b0;
        #1;
        cmp("reset m_valid", 96'(m_valid), 96'(0));
        cmp("reset s_ready", 96'(s_ready), 96'(0));
        cmp("reset m_data", 96'(m_data), 96'(0));
        cmp("reset m_lane", 96'(m_lane), 96'(0));
        sb.delete();
        owner = -1;
        last_winner = N - 1;
        mv = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic checkOutput();
        exp_t e;
        exp_t cur;
        cur = {m_lane, m_data, m_strb, m_keep, m_last, m_id, m_dest, m_user};
        if (!rstn || !m_valid) begin
            stalled = 1'b0;
            return;
        end
        if (stalled) cmp("stall hold", 96'(cur), 96'(stall_snap));
        if (m_ready) begin
            stalled = 1'b0;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected beat: got 0x%0h, expected none at %0t", cur, $time);
            end else begin
                e = sb.pop_front();
                cmp("beat lane", 96'(m_lane), 96'(e.lane));
                cmp("beat last", 96'(m_last), 96'(e.beat.last));
                cmp("beat fields", 96'(cur.beat), 96'(e.beat));
            end
        end else begin
            stalled = 1'b1;
            stall_snap = cur;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    initial begin
        int drain;
        setProbs(0, 0, 0, 0, 100);
        @(posedge clk);
        #1;
        s_valid = '1;
        doReset();

        $display("[TB] lane 2 three-beat packet");
        pushPacket(2, 3, 64'hA, 1'b1);
        setProbs(0, 0, 100, 0, 100);
        repeat (6) applyStimulus();

        $display("[TB] single-beat packets on all lanes");
        doReset();
        for (int l = 0; l < N; l++) begin
            pushPacket(l, 1, '0, 1'b0);
            pushPacket(l, 1, '0, 1'b0);
        end
        setProbs(100, 100, 100, 100, 100);
        repeat (10) applyStimulus();

        $display("[TB] lane 1 locks while lanes 0 and 3 wait");
        pushPacket(1, 4, '0, 1'b0);
        pushPacket(0, 1, '0, 1'b0);
        pushPacket(3, 1, '0, 1'b0);
        setProbs(0, 100, 0, 0, 100);
        applyStimulus();
        setProbs(100, 100, 100, 100, 100);
        repeat (8) applyStimulus();

        $display("[TB] output stall mid-packet");
        pushPacket(0, 6, '0, 1'b0);
        setProbs(100, 0, 0, 0, 100);
        repeat (2) applyStimulus();
        setProbs(100, 0, 0, 0, 0);
        repeat (5) applyStimulus();
        setProbs(100, 0, 0, 0, 100);
        repeat (6) applyStimulus();

        $display("[TB] reset mid-packet");
        pushPacket(1, 4, '0, 1'b0);
        setProbs(0, 100, 0, 0, 100);
        repeat (2) applyStimulus();
        doReset();
        pushPacket(0, 1, '0, 1'b0);
        setProbs(100, 100, 0, 0, 100);
        repeat (6) applyStimulus();

        $display("[TB] locked lane pauses mid-packet");
        pushPacket(2, 3, '0, 1'b0);
        pushPacket(0, 2, '0, 1'b0);
        setProbs(0, 0, 100, 0, 100);
        applyStimulus();
        setProbs(100, 0, 0, 0, 100);
        repeat (3) applyStimulus();
        setProbs(100, 0, 100, 0, 100);
        repeat (6) applyStimulus();

        $display("[TB] random traffic");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 25 == 0)
                setProbs($urandom_range(0, 100), $urandom_range(0, 100),
                         $urandom_range(0, 100), $urandom_range(0, 100),
                         $urandom_range(20, 100));
            for (int l = 0; l < N; l++)
                if (lane_q[l].size() < 2) pushPacket(l, $urandom_range(1, 4), '0, 1'b0);
            if ($urandom_range(0, 599) == 0) doReset();
            else applyStimulus();
        end

        setProbs(0, 0, 0, 0, 100);
        drain = 0;
        while ((sb.size() > 0 || m_valid) && drain < 20) begin
            applyStimulus();
            drain++;
        end
        cmp("scoreboard drained", 96'(sb.size()), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
